// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: shared types and constants for the banked Wishbone RAM bridge.
//   wb_ram_state_e : bridge FSM states (IDLE, REQ, WAIT, RESP)
//   MAX_BANKS      : upper bound on NUM_BANKS
//   MAX_RD_LATENCY : upper bound on RD_LATENCY
//   WB_DATA_W      : Wishbone / RAM data width
//   WB_SEL_W       : byte-select width
//   BANK_IDX_W     : width of a bank index (covers MAX_BANKS)
//   CNT_W          : width of the read-latency counter (covers MAX_RD_LATENCY-1)
package wb_ram_pkg;

  localparam int MAX_BANKS      = 8;
  localparam int MAX_RD_LATENCY = 4;
  localparam int WB_DATA_W      = 32;
  localparam int WB_SEL_W       = 4;
  localparam int BANK_IDX_W     = 3;
  localparam int CNT_W          = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_ram_state_e;

endpackage

// File: rtl/wb_ram_banked_if_bank_decode.sv
// wb_ram_bank_decode: combinational bank decoder.
// Compares the bank-select field addr[BANK_SEL_LSB +: BANK_SEL_W] against each
// bank's match value in BANK_BASE. The lowest-numbered matching bank wins.
// Ports:
//   addr     in  32          byte address
//   bank_idx out BANK_IDX_W  index of the selected bank (0 when no match)
//   hit      out 1           at least one bank matched
module wb_ram_bank_decode
  import wb_ram_pkg::*;
#(
  parameter int                            NUM_BANKS    = 2,
  parameter int                            BANK_SEL_LSB = 13,
  parameter int                            BANK_SEL_W   = 7,
  parameter logic [NUM_BANKS*BANK_SEL_W-1:0] BANK_BASE  = {7'h19, 7'h18}
) (
  input  logic [31:0]           addr,
  output logic [BANK_IDX_W-1:0] bank_idx,
  output logic                  hit
);

  logic [BANK_SEL_W-1:0] field;
  assign field = addr[BANK_SEL_LSB +: BANK_SEL_W];

  // Only the bank-select field is meaningful here.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    bank_idx = '0;
    hit      = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (field == BANK_BASE[i*BANK_SEL_W +: BANK_SEL_W]) begin
        bank_idx = BANK_IDX_W'(i);
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ram_banked_if.sv
// wb_ram_banked_if: Wishbone classic slave bridging to NUM_BANKS single-port RAMs.
// A request is latched in IDLE, the RAM is strobed for one cycle in REQ, read
// data is awaited for RD_LATENCY cycles in WAIT, and RESP carries a one-cycle
// ack (or err). All outputs are registered.
//
// Handshake: a request is taken when wb_cyc_i & wb_stb_i are high in IDLE;
// wb_stb_i is ignored in every other state. wb_ack_o / wb_err_o pulse for
// exactly one cycle. If wb_cyc_i is low at the edge that would raise the
// response, the transaction is dropped silently (issued writes stay written).
//
// Optional feature macro WB_RAM_ERR_EN: unmapped accesses answer with wb_err_o;
// without it they answer with wb_ack_o and zero read data, and wb_err_o is 0.
//
// Ports:
//   wb_clk_i, rst_ni (sync, active-low)
//   wb_addr_i, wb_wdata_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i : Wishbone request
//   wb_rdata_o, wb_ack_o, wb_err_o                              : Wishbone response
//   ram_addr_o, ram_wdata_o, ram_be_o, ram_en_o, ram_we_o       : RAM strobe (shared addr/data, one-hot en/we)
//   ram_rdata_i                                                 : bank i read data at [i*32 +: 32]
module wb_ram_banked_if
  import wb_ram_pkg::*;
#(
  parameter int                              NUM_BANKS      = 2,
  parameter int                              RAM_ADDR_WIDTH = 11,
  parameter int                              BANK_SEL_LSB   = 13,
  parameter int                              BANK_SEL_W     = 7,
  parameter logic [NUM_BANKS*BANK_SEL_W-1:0] BANK_BASE      = {7'h19, 7'h18},
  parameter int                              RD_LATENCY     = 1
) (
  input  logic                          wb_clk_i,
  input  logic                          rst_ni,
  input  logic [31:0]                   wb_addr_i,
  input  logic [WB_DATA_W-1:0]          wb_wdata_i,
  input  logic [WB_SEL_W-1:0]           wb_sel_i,
  input  logic                          wb_we_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_cyc_i,
  output logic [WB_DATA_W-1:0]          wb_rdata_o,
  output logic                          wb_ack_o,
  output logic                          wb_err_o,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [WB_DATA_W-1:0]          ram_wdata_o,
  output logic [WB_SEL_W-1:0]           ram_be_o,
  output logic [NUM_BANKS-1:0]          ram_en_o,
  output logic [NUM_BANKS-1:0]          ram_we_o,
  input  logic [NUM_BANKS*WB_DATA_W-1:0] ram_rdata_i
);

  if (NUM_BANKS < 1 || NUM_BANKS > MAX_BANKS) begin : g_bad_num_banks
    $error("wb_ram_banked_if: NUM_BANKS out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_latency
    $error("wb_ram_banked_if: RD_LATENCY out of range");
  end

  wb_ram_state_e         state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BANK_IDX_W-1:0] bank_q;
  logic                  hit_q;
  logic                  we_q;

  logic [BANK_IDX_W-1:0] dec_bank;
  logic                  dec_hit;
  logic [NUM_BANKS-1:0]  dec_onehot;
  logic [WB_DATA_W-1:0]  rd_sel;

  wb_ram_bank_decode #(
    .NUM_BANKS   (NUM_BANKS),
    .BANK_SEL_LSB(BANK_SEL_LSB),
    .BANK_SEL_W  (BANK_SEL_W),
    .BANK_BASE   (BANK_BASE)
  ) u_decode (
    .addr    (wb_addr_i),
    .bank_idx(dec_bank),
    .hit     (dec_hit)
  );

  // One-hot strobe for the decoded bank; all zero on a miss.
  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      dec_onehot[i] = dec_hit && (dec_bank == BANK_IDX_W'(i));
    end
  end

  // Read-data mux for the bank latched with the request.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_q == BANK_IDX_W'(i)) rd_sel = ram_rdata_i[i*WB_DATA_W +: WB_DATA_W];
    end
  end

`ifndef WB_RAM_ERR_EN
  assign wb_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      hit_q       <= 1'b0;
      we_q        <= 1'b0;
      wb_rdata_o  <= '0;
      wb_ack_o    <= 1'b0;
`ifdef WB_RAM_ERR_EN
      wb_err_o    <= 1'b0;
`endif
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_be_o    <= '0;
      ram_en_o    <= '0;
      ram_we_o    <= '0;
    end else begin
      // Strobes and responses are single-cycle pulses by default.
      ram_en_o <= '0;
      ram_we_o <= '0;
      wb_ack_o <= 1'b0;
`ifdef WB_RAM_ERR_EN
      wb_err_o <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            ram_addr_o  <= wb_addr_i[RAM_ADDR_WIDTH+1:2];
            ram_wdata_o <= wb_wdata_i;
            ram_be_o    <= wb_sel_i;
            ram_en_o    <= dec_onehot;
            // A write with no byte selected still strobes the bank but writes nothing.
            ram_we_o    <= (wb_we_i && (wb_sel_i != '0)) ? dec_onehot : '0;
            bank_q      <= dec_bank;
            hit_q       <= dec_hit;
            we_q        <= wb_we_i;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else if (!hit_q) begin
            wb_rdata_o <= '0;
`ifdef WB_RAM_ERR_EN
            wb_err_o   <= 1'b1;
`else
            wb_ack_o   <= 1'b1;
`endif
            state_q    <= RESP;
          end else if (we_q) begin
            wb_ack_o <= 1'b1;
            state_q  <= RESP;
          end else begin
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            wb_rdata_o <= rd_sel;
            wb_ack_o   <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
